// File: rtl/bydin_pkg.sv
// Shared definitions for the byte-deinterleaver SRAM arbiter: widths,
// requester ids, starvation limit and the read-tag record.
package bydin_pkg;

   localparam int BYDIN_AW       = 17;
   localparam int STARVE_MAX_DEF = 15;
   localparam int STARVE_W       = 4;

   localparam int REQ_WR = 0;
   localparam int REQ_RS = 1;
   localparam int REQ_TS = 2;

   typedef enum logic {
      TAG_RS = 1'b0,
      TAG_TS = 1'b1
   } tag_id_e;

   typedef struct packed {
      logic    vld;
      tag_id_e id;
   } rd_tag_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/bydin_mem_arb_if.sv
// Requester-side bus of the deinterleaver SRAM arbiter: requests, grants
// and tagged read-data return.
interface bydin_mem_arb_if
   import bydin_pkg::*;
#(parameter int AW = BYDIN_AW);

   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_din;
   logic          rs_req;
   logic          rs_we;
   logic [AW-1:0] rs_addr;
   logic [7:0]    rs_din;
   logic          ts_req;
   logic [AW-1:0] ts_addr;
   logic          wr_gnt;
   logic          rs_gnt;
   logic          ts_gnt;
   logic          rs_rvld;
   logic          ts_rvld;
   logic [7:0]    rd_data;
   logic          mdo_en;
   logic          ts_starve;

   modport master (
      output wr_req, wr_addr, wr_din, rs_req, rs_we, rs_addr, rs_din,
             ts_req, ts_addr,
      input  wr_gnt, rs_gnt, ts_gnt, rs_rvld, ts_rvld, rd_data, mdo_en,
             ts_starve
   );

   modport slave (
      input  wr_req, wr_addr, wr_din, rs_req, rs_we, rs_addr, rs_din,
             ts_req, ts_addr,
      output wr_gnt, rs_gnt, ts_gnt, rs_rvld, ts_rvld, rd_data, mdo_en,
             ts_starve
   );

endinterface

// File: rtl/bydin_rd_tag_pipe.sv
// Valid/id delay line matching the SRAM read latency; DEPTH is the number
// of cycles from grant to read data.
module bydin_rd_tag_pipe
   import bydin_pkg::*;
#(parameter int DEPTH = 2)
(
   input  logic    clk,
   input  logic    reset_n,
   input  rd_tag_t tag_in,
   output rd_tag_t tag_out
);

   rd_tag_t [DEPTH-1:0] stage;

   // NOTE: this shift register is reset, unlike a data RAM, because a stale
   // valid bit surviving reset would fire a read-valid nobody asked for.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage <= '0;
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/bydin_mem_arb.sv
// Single-port SRAM arbiter for the byte deinterleaver (WR > promoted TS > RS > TS).
// Optional statistics counters are built when BYDIN_ARB_STAT_EN is defined.
module bydin_mem_arb
   import bydin_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF,
   parameter int AW         = BYDIN_AW
)
(
   input  logic          clk,
   input  logic          reset_n,
   bydin_mem_arb_if.slave bus,
   output logic          mem_en,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_di,
   input  logic [7:0]    mem_do
`ifdef BYDIN_ARB_STAT_EN
   ,
   input  logic          stat_clr,
   output logic [15:0]   stat_wr_cnt,
   output logic [15:0]   stat_rs_cnt,
   output logic [15:0]   stat_ts_cnt,
   output logic [15:0]   stat_conf_cnt
`endif
);

   logic [2:0]          req;
   logic [2:0]          gnt;
   logic [STARVE_W-1:0] starve_cnt;
   logic                promoted;
   rd_tag_t             tag_in;
   rd_tag_t             tag_out;

   assign req[REQ_WR] = bus.wr_req;
   assign req[REQ_RS] = bus.rs_req;
   assign req[REQ_TS] = bus.ts_req;

   assign promoted = bus.ts_req && (starve_cnt == STARVE_W'(STARVE_MAX));

   // NOTE: every output of this block gets a default first so no latch is
   // inferred; grants are also held low while reset is asserted.
   always_comb begin
      gnt = '0;
      if (reset_n) begin
         if (req[REQ_WR])      gnt[REQ_WR] = 1'b1;
         else if (promoted)    gnt[REQ_TS] = 1'b1;
         else if (req[REQ_RS]) gnt[REQ_RS] = 1'b1;
         else if (req[REQ_TS]) gnt[REQ_TS] = 1'b1;
      end
   end

   assign bus.wr_gnt    = gnt[REQ_WR];
   assign bus.rs_gnt    = gnt[REQ_RS];
   assign bus.ts_gnt    = gnt[REQ_TS];
   assign bus.ts_starve = gnt[REQ_TS] & promoted;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt <= '0;
      end else if (!bus.ts_req || gnt[REQ_TS]) begin
         starve_cnt <= '0;
      end else if (starve_cnt != STARVE_W'(STARVE_MAX)) begin
         starve_cnt <= starve_cnt + STARVE_W'(1);
      end
   end

   // Idle cycles keep the last address/data and only drop the enable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_en   <= 1'b0;
         mem_wr   <= 1'b0;
         mem_addr <= '0;
         mem_di   <= '0;
      end else begin
         mem_en <= |gnt;
         mem_wr <= gnt[REQ_WR] | (gnt[REQ_RS] & bus.rs_we);
         if (gnt[REQ_WR]) begin
            mem_addr <= bus.wr_addr;
            mem_di   <= bus.wr_din;
         end else if (gnt[REQ_RS]) begin
            mem_addr <= bus.rs_addr;
            if (bus.rs_we) mem_di <= bus.rs_din;
         end else if (gnt[REQ_TS]) begin
            mem_addr <= bus.ts_addr;
         end
      end
   end

   assign tag_in.vld = (gnt[REQ_RS] & ~bus.rs_we) | gnt[REQ_TS];
   assign tag_in.id  = gnt[REQ_TS] ? TAG_TS : TAG_RS;

   bydin_rd_tag_pipe #(.DEPTH(2)) u_tag_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   assign bus.rs_rvld = tag_out.vld & (tag_out.id == TAG_RS);
   assign bus.ts_rvld = tag_out.vld & (tag_out.id == TAG_TS);
   assign bus.mdo_en  = tag_out.vld;
   assign bus.rd_data = mem_do;

`ifdef BYDIN_ARB_STAT_EN
   logic conflict;
   assign conflict = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);

   // Clear has priority over any coincident increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n || stat_clr) begin
         stat_wr_cnt   <= '0;
         stat_rs_cnt   <= '0;
         stat_ts_cnt   <= '0;
         stat_conf_cnt <= '0;
      end else begin
         if (gnt[REQ_WR]) stat_wr_cnt   <= sat_inc16(stat_wr_cnt);
         if (gnt[REQ_RS]) stat_rs_cnt   <= sat_inc16(stat_rs_cnt);
         if (gnt[REQ_TS]) stat_ts_cnt   <= sat_inc16(stat_ts_cnt);
         if (conflict)    stat_conf_cnt <= sat_inc16(stat_conf_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_bydin_mem_arb.sv
// Directed bench for bydin_mem_arb: grant/command vector table plus
// sequences for read latency, ordering, starvation, hazards and reset.
module tb_bydin_mem_arb;
   import bydin_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        mem_en, mem_wr;
   logic [16:0] mem_addr;
   logic [7:0]  mem_di;
   logic [7:0]  mem_do = 8'h00;
   logic [7:0]  sram [0:(1<<17)-1];
   int          n_checks = 0;
   int          n_pass = 0;
`ifdef BYDIN_ARB_STAT_EN
   logic        stat_clr = 1'b0;
   logic [15:0] stat_wr_cnt, stat_rs_cnt, stat_ts_cnt, stat_conf_cnt;
`endif

   bydin_mem_arb_if #(.AW(17)) bus ();

   bydin_mem_arb #(.STARVE_MAX(15), .AW(17)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .mem_en   (mem_en),
      .mem_wr   (mem_wr),
      .mem_addr (mem_addr),
      .mem_di   (mem_di),
      .mem_do   (mem_do)
`ifdef BYDIN_ARB_STAT_EN
      ,
      .stat_clr      (stat_clr),
      .stat_wr_cnt   (stat_wr_cnt),
      .stat_rs_cnt   (stat_rs_cnt),
      .stat_ts_cnt   (stat_ts_cnt),
      .stat_conf_cnt (stat_conf_cnt)
`endif
   );

   always #5 clk = ~clk;

   // SRAM behavioural model: one-cycle read latency.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_wr) sram[mem_addr] <= mem_di;
         else        mem_do <= sram[mem_addr];
      end
   end

   typedef struct {
      logic        wr, rs, we, ts;
      logic [16:0] addr;
      logic [7:0]  din;
      logic [2:0]  gnt;   // {wr, rs, ts}
      logic        en, mwr;
      logic [16:0] maddr;
      logic [7:0]  mdi;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic idle_reqs();
      bus.wr_req = 1'b0;
      bus.rs_req = 1'b0;
      bus.rs_we  = 1'b0;
      bus.ts_req = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] gnts();
      return {bus.wr_gnt, bus.rs_gnt, bus.ts_gnt};
   endfunction

   task automatic wr_one(input logic [16:0] addr, input logic [7:0] din);
      bus.wr_req  = 1'b1;
      bus.wr_addr = addr;
      bus.wr_din  = din;
      step();
      bus.wr_req = 1'b0;
   endtask

   task automatic ts_read(input string tag, input logic [16:0] addr, input logic [7:0] exp);
      bus.ts_req  = 1'b1;
      bus.ts_addr = addr;
      @(negedge clk);
      check({tag, "_gnt"}, gnts(), 3'b001);
      step();
      bus.ts_req = 1'b0;
      @(negedge clk);
      check({tag, "_cmd"}, {mem_en, mem_wr, mem_addr}, {1'b1, 1'b0, addr});
      @(negedge clk);
      check({tag, "_rvld"}, {bus.ts_rvld, bus.rs_rvld, bus.mdo_en}, 3'b101);
      check({tag, "_data"}, bus.rd_data, exp);
      step();
   endtask

   initial begin
      int          wr_c, rs_c, ts_c, got;
      logic        early;
      logic [2:0]  g15, g16, g17;
      logic        s17;

      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 17'h00001, 8'h00, 3'b000, 1'b0, 1'b0, 17'h00000, 8'h00};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 17'h00010, 8'h11, 3'b100, 1'b1, 1'b1, 17'h00010, 8'h11};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 17'h00020, 8'h22, 3'b010, 1'b1, 1'b0, 17'h00020, 8'h11};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 17'h00030, 8'h33, 3'b010, 1'b1, 1'b1, 17'h00030, 8'h33};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 17'h00040, 8'h44, 3'b001, 1'b1, 1'b0, 17'h00040, 8'h33};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 17'h00050, 8'h55, 3'b100, 1'b1, 1'b1, 17'h00050, 8'h55};
      vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 17'h1FFFF, 8'h66, 3'b000, 1'b0, 1'b0, 17'h00050, 8'h55};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 17'h1FFFF, 8'hFF, 3'b100, 1'b1, 1'b1, 17'h1FFFF, 8'hFF};
      vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 17'h00000, 8'h77, 3'b001, 1'b1, 1'b0, 17'h00000, 8'hFF};

      idle_reqs();
      bus.wr_addr = '0; bus.wr_din = '0;
      bus.rs_addr = '0; bus.rs_din = '0;
      bus.ts_addr = '0;

      // Reset state, with a write request that must not be granted.
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      bus.wr_req = 1'b1;
      #1;
      check("reset_gnt", gnts(), 3'b000);
      check("reset_outs", {mem_en, mem_wr, mem_addr, mem_di, bus.rs_rvld, bus.ts_rvld,
                           bus.mdo_en, bus.ts_starve}, '0);
      bus.wr_req = 1'b0;
      step();
      reset_n = 1'b1;
      step();

      for (int i = 0; i < 9; i++) begin
         bus.wr_req  = vecs[i].wr;
         bus.rs_req  = vecs[i].rs;
         bus.rs_we   = vecs[i].we;
         bus.ts_req  = vecs[i].ts;
         bus.wr_addr = vecs[i].addr;
         bus.rs_addr = vecs[i].addr;
         bus.ts_addr = vecs[i].addr;
         bus.wr_din  = vecs[i].din;
         bus.rs_din  = vecs[i].din;
         @(negedge clk);
         check($sformatf("vec%0d_gnt", i), gnts(), vecs[i].gnt);
         step();
         idle_reqs();
         @(negedge clk);
         check($sformatf("vec%0d_mem", i), {mem_en, mem_wr, mem_addr, mem_di},
               {vecs[i].en, vecs[i].mwr, vecs[i].maddr, vecs[i].mdi});
         step();
      end
      repeat (2) step();

      // Single TS read with known SRAM content.
      wr_one(17'h00123, 8'h5A);
      ts_read("ts_read", 17'h00123, 8'h5A);

      // All three requesting at once.
      bus.wr_req = 1'b1; bus.wr_addr = 17'h00200; bus.wr_din = 8'hA1;
      bus.rs_req = 1'b1; bus.rs_we = 1'b0; bus.rs_addr = 17'h00201;
      bus.ts_req = 1'b1; bus.ts_addr = 17'h00202;
      wr_c = 99; rs_c = 99; ts_c = 99;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check($sformatf("one_gnt_c%0d", c), ($countones(gnts()) <= 1), 1'b1);
         if (bus.wr_gnt && wr_c == 99) wr_c = c;
         if (bus.rs_gnt && rs_c == 99) rs_c = c;
         if (bus.ts_gnt && ts_c == 99) ts_c = c;
         step();
         if (wr_c != 99) bus.wr_req = 1'b0;
         if (rs_c != 99) bus.rs_req = 1'b0;
         if (ts_c != 99) bus.ts_req = 1'b0;
         if (wr_c != 99 && rs_c != 99 && ts_c != 99) break;
      end
      idle_reqs();
      check("order_wr", wr_c, 0);
      check("order_rs", rs_c, 1);
      check("order_ts", ts_c, 2);
      repeat (3) step();

      // Continuous RS traffic must not starve TS beyond 16 cycles.
      bus.rs_req = 1'b1; bus.rs_we = 1'b0; bus.rs_addr = 17'h00300;
      bus.ts_req = 1'b1; bus.ts_addr = 17'h00301;
      got = 99; early = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.ts_gnt) begin
            got = c;
            check("starve_pulse", {bus.ts_starve, bus.rs_gnt}, 2'b10);
            step();
            break;
         end
         if (bus.ts_starve) early = 1'b1;
         step();
      end
      idle_reqs();
      check("starve_grant_cycle", got, 15);
      check("starve_no_early_pulse", early, 1'b0);
      repeat (3) step();

      // Promoted TS still yields to WR and persists until granted.
      bus.rs_req = 1'b1; bus.rs_we = 1'b0; bus.rs_addr = 17'h00310;
      bus.ts_req = 1'b1; bus.ts_addr = 17'h00311;
      bus.wr_addr = 17'h00312; bus.wr_din = 8'hB2;
      g15 = '0; g16 = '0; g17 = '0; s17 = 1'b0;
      for (int c = 0; c < 18; c++) begin
         if (c == 15) bus.wr_req = 1'b1;
         if (c == 17) bus.wr_req = 1'b0;
         @(negedge clk);
         if (c == 15) g15 = gnts();
         if (c == 16) g16 = gnts();
         if (c == 17) begin g17 = gnts(); s17 = bus.ts_starve; end
         step();
      end
      idle_reqs();
      check("promo_wr_override_0", g15, 3'b100);
      check("promo_wr_override_1", g16, 3'b100);
      check("promo_ts_after_wr", {g17, s17}, 4'b0011);
      repeat (3) step();

      // RS write then RS read of the same address.
      bus.rs_req = 1'b1; bus.rs_we = 1'b1; bus.rs_addr = 17'h1F000; bus.rs_din = 8'hC3;
      @(negedge clk);
      check("raw_wr_gnt", gnts(), 3'b010);
      step();
      bus.rs_we = 1'b0;
      @(negedge clk);
      check("raw_rd_gnt", gnts(), 3'b010);
      step();
      idle_reqs();
      @(negedge clk);
      check("raw_no_rvld_for_write", bus.rs_rvld, 1'b0);
      @(negedge clk);
      check("raw_rvld", {bus.rs_rvld, bus.ts_rvld}, 2'b10);
      check("raw_data", bus.rd_data, 8'hC3);
      repeat (3) step();

      // Reset with two reads in flight.
      bus.rs_req = 1'b1; bus.rs_we = 1'b0; bus.rs_addr = 17'h00030;
      step();
      bus.rs_addr = 17'h00010;
      step();
      idle_reqs();
      reset_n = 1'b0;
      #1;
      check("midrst_outs", {gnts(), mem_en, mem_wr, mem_addr, mem_di, bus.rs_rvld, bus.ts_rvld,
                            bus.mdo_en, bus.ts_starve}, '0);
      repeat (2) step();
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("postrst_no_rvld_c%0d", c), {bus.rs_rvld, bus.ts_rvld, bus.mdo_en}, 3'b000);
      end
      step();
      ts_read("postrst_read", 17'h00123, 8'h5A);

`ifdef BYDIN_ARB_STAT_EN
      bus.wr_req = 1'b1; bus.wr_addr = 17'h00400; bus.wr_din = 8'h01;
      repeat (70000) step();
      @(negedge clk);
      check("stat_wr_sat", stat_wr_cnt, 16'hFFFF);
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
      bus.wr_req = 1'b0;
      @(negedge clk);
      check("stat_clr_wins", {stat_wr_cnt, stat_rs_cnt, stat_ts_cnt, stat_conf_cnt}, '0);
      step();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bydin_mem_arb.md
# bydin_mem_arb

Single-port arbiter for the byte-deinterleaver SRAM (17-bit address, 8-bit data). It sits between the SRAM macro and three requesters: the byte-input writer, the RS decoder read/write-back path, and the TS readout path. It serialises their accesses onto one memory port and returns tagged read data. It also guarantees that the TS readout cannot be starved by long RS decode bursts.

## Interface
- STARVE_MAX, 15: consecutive cycles a pending TS request may lose to RS before it is promoted.
- AW, 17: memory address width.
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- wr_req / wr_addr / wr_din  in  1/AW/8  byte-input write request (write only)
- rs_req / rs_we / rs_addr / rs_din  in  1/1/AW/8  RS path request
- ts_req / ts_addr  in  1/AW  TS readout request (read only)
- wr_gnt / rs_gnt / ts_gnt  out  1 each  grant, combinational, same cycle as the winning request
- rs_rvld / ts_rvld  out  1 each  read data valid for that requester
- rd_data  out  8  shared read data; equals mem_do
- mem_en / mem_wr / mem_addr / mem_di  out  1/1/AW/8  registered SRAM command
- mem_do  in  8  SRAM read data, valid 1 cycle after a read command
- mdo_en  out  1  any read data valid (rs_rvld | ts_rvld)
- ts_starve  out  1  pulse: TS promotion taken this cycle
- stat_clr  in  1  clear statistics (only with BYDIN_ARB_STAT_EN)
- stat_wr_cnt / stat_rs_cnt / stat_ts_cnt / stat_conf_cnt  out  16 each  statistics (only with BYDIN_ARB_STAT_EN)

## Operation
- Requesters hold req, addr, data and we stable until the matching gnt is seen high at a clock edge. After that edge they may change them.
- Priority, evaluated every cycle:
  - wr_req always wins. The input stream cannot stall.
  - Otherwise, a promoted TS request wins.
  - Otherwise RS wins over TS.
- At most one gnt is high per cycle. No gnt is high when no request is pending.
- Starvation counter (4 bits):
  - Increments each cycle ts_req is high and ts_gnt is low.
  - Clears on ts_gnt or when ts_req is low.
  - At count == STARVE_MAX the TS request is promoted. ts_starve pulses in the cycle the promoted grant is given.
  - The counter saturates at STARVE_MAX and does not wrap.
  - wr_req still overrides a promoted TS request. The promotion persists until TS is granted.
- Granted command is registered onto mem_* the next cycle:
  - mem_en = 1.
  - mem_wr = 1 for a write grant, 0 for a read grant.
  - mem_di is valid for writes.
- mem_* holds its previous address and data with mem_en = 0 in idle cycles.
- Read tag pipeline: a 2-stage shift register of {valid, id}. id is 0 for RS and 1 for TS.
  - Stage 0 loads on a read grant.
  - Stage 1 drives rs_rvld or ts_rvld.
- Reads and writes to the same address in consecutive grants keep program order, because the port is single and in-order.
- Reset, including mid-operation:
  - All outputs are 0: gnts, rvlds, mem_en, mem_wr, mem_addr, mem_di, mdo_en, ts_starve, and all counters.
  - In-flight reads are discarded. No rvld is issued for them after reset release.

## Timing
- Grant to memory command: 1 cycle (cycle T grant, T+1 mem_en).
- Grant to read data: 2 cycles. rs_rvld or ts_rvld is high at T+2, with rd_data = mem_do in that same cycle.
- Throughput: one access per cycle, back-to-back with no bubbles.
- Simultaneous wr_req + rs_req + ts_req:
  - Cycle 1 grants WR.
  - The next free cycle grants RS, unless TS is promoted.
- A requester dropping req before gnt: the request is withdrawn with no access. This is legal only for rs_req.

## Configuration
- BYDIN_ARB_STAT_EN defined:
  - Four 16-bit saturating counters: grants per requester, plus conflict cycles. A conflict cycle is one with two or more requests pending.
  - stat_clr zeroes all four synchronously.
  - If stat_clr and an increment coincide, the clear wins.
- Undefined: the stat_* ports and stat_clr are absent and no counter logic is built.

## Structure
- Shared package bydin_pkg holds:
  - BYDIN_AW = 17.
  - Requester id constants REQ_WR = 0, REQ_RS = 1, REQ_TS = 2.
  - STARVE_MAX default.
- One natural sub-module, bydin_rd_tag_pipe: the 2-stage valid/id delay line, parameterised on depth for a future 2-cycle SRAM.

## Test plan
- Single TS read at addr 0x00123, SRAM holding 0x5A → ts_gnt at T, mem_en=1/mem_wr=0/mem_addr=0x00123 at T+1, ts_rvld=1 and rd_data=0x5A at T+2.
- wr_req, rs_req and ts_req all high at once → wr_gnt, then rs_gnt, then ts_gnt on consecutive cycles. Never two gnts in one cycle.
- rs_req continuously high and ts_req high → ts_gnt within STARVE_MAX+1 = 16 cycles, with a ts_starve pulse in that cycle.
- RS write 0xC3 to 0x1F000 immediately followed by an RS read of 0x1F000 → rs_rvld with rd_data=0xC3.
- Assert reset_n low with two reads in flight → all outputs 0. After release, no rvld appears until new grants.
- With BYDIN_ARB_STAT_EN: 70000 WR grants → stat_wr_cnt = 0xFFFF. A stat_clr on the same cycle as a grant → 0.
